fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's 16×8 FIFO. It adds configurable width and depth, same-cycle read and write, a live occupancy count, programmable almost-full and almost-empty thresholds, a read-valid strobe, and sticky overflow/underflow error flags. It sits between producer and consumer logic in a single clock domain and is the default buffering primitive for new datapaths.

---
 rtl/fifo_sync_param.sv | 125 ++++++++++++
 tb/tb_fifo_sync_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Parametrised single-clock FIFO with occupancy count, almost-full /
//   almost-empty thresholds, a read-valid strobe and sticky error flags.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   wr, din       write request and write data
//   rd            read request
//   dout          registered read data (holds between reads)
//   rd_valid      one-cycle pulse: dout carries newly read data
//   count         occupancy, 0..DEPTH
//   empty, full   count == 0, count == DEPTH
//   almost_empty  count <= AEMPTY_TH
//   almost_full   count >= AFULL_TH
//   overflow      sticky: write requested while full
//   underflow     sticky: read requested while empty
//   err_clr       clears overflow/underflow (a same-cycle set wins)
//
// Handshake: wr and rd are requests, not held handshakes. A write is
// accepted on an edge where wr=1 and full=0; a read is accepted on an edge
// where rd=1 and empty=0. Rejected requests are dropped (and flagged), never
// retried. Both decisions use the pre-edge count only, so a same-cycle write
// never makes a read legal on an empty FIFO and a same-cycle read never makes
// a write legal on a full one.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status is decoded from the count register alone, so no output has a
  // combinational path from wr or rd.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign almost_full  = (count >= AFULL_C);

  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  // Storage is intentionally not reset; stale entries are unreachable
  // because the pointers and count are.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      dout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + AW'(1);
      end
      // The read uses the pre-edge rptr, so data written this cycle is
      // never bypassed to dout.
      if (rd_acc) begin
        dout <= mem[rptr];
        rptr <= rptr + AW'(1);
      end
      rd_valid <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a set condition in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
//   Directed scenarios followed by a randomized phase for fifo_sync_param
//   (DATA_WIDTH=8, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2). Expected values come
//   from a queue-based model of the FIFO's contents and sticky flags.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  // Clock / reset / DUT signals
  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [DW-1:0] din;
  logic          rd;
  logic [DW-1:0] dout;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic          overflow;
  logic          underflow;
  logic          err_clr;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_TH   (AF),
    .AEMPTY_TH  (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .din          (din),
    .rd           (rd),
    .dout         (dout),
    .rd_valid     (rd_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  // Scoreboard / reference model
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout  = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf   = 1'b0;
  logic          m_udf   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge,
  // then compare every output against the model.
  task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                      input logic rr, input logic c);
    int sz;
    sz      = exp_q.size();
    rst     = r;
    wr      = w;
    din     = d;
    rd      = rr;
    err_clr = c;
    if (r) begin
      exp_q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      m_valid = rr && (sz > 0);
      if (m_valid) m_dout = exp_q.pop_front();
      if (w && (sz < DEPTH)) exp_q.push_back(d);
      if (w && (sz == DEPTH)) m_ovf = 1'b1;
      else if (c)             m_ovf = 1'b0;
      if (rr && (sz == 0))    m_udf = 1'b1;
      else if (c)             m_udf = 1'b0;
    end
    @(posedge clk);
    #1;
    sz = exp_q.size();
    chk("dout",         32'(dout),         32'(m_dout));
    chk("rd_valid",     32'(rd_valid),     32'(m_valid));
    chk("count",        32'(count),        32'(sz));
    chk("empty",        32'(empty),        32'(sz == 0));
    chk("full",         32'(full),         32'(sz == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    chk("almost_full",  32'(almost_full),  32'(sz >= AF));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
    rst     = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; din = '0;

    // Reset
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_aempty", 32'(almost_empty), 32'd1);

    // Fill with 0x00..0x0F, then a 17th write sets overflow
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, DW'(i), 0, 0);
      if (i == 2)  chk("aempty_drop_at_3", 32'(almost_empty), 32'd0);
      if (i == 13) chk("afull_rise_at_14", 32'(almost_full), 32'd1);
    end
    chk("full_after_fill", 32'(full), 32'd1);
    step(0, 1, 8'hAA, 0, 0);
    chk("ovf_17th_write", 32'(overflow), 32'd1);
    chk("count_stays_16", 32'(count), 32'd16);

    // err_clr alongside a rejected write: set wins; then a plain clear
    step(0, 1, 8'hBB, 0, 1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    step(0, 0, 8'h00, 0, 1);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Drain 16, then one extra read
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk("drain_data", 32'(dout), 32'(i));
    end
    chk("empty_after_drain", 32'(empty), 32'd1);
    step(0, 0, 8'h00, 1, 0);
    chk("udf_extra_read", 32'(underflow), 32'd1);
    chk("dout_holds_0f", 32'(dout), 32'h0F);
    step(0, 0, 8'h00, 0, 1);

    // Empty with wr & rd: write accepted, read rejected, no bypass
    step(0, 1, 8'h77, 1, 0);
    chk("empty_wr_rd_count", 32'(count), 32'd1);
    chk("empty_wr_rd_valid", 32'(rd_valid), 32'd0);
    chk("empty_wr_rd_udf", 32'(underflow), 32'd1);
    step(0, 0, 8'h00, 1, 1);

    // Wrap-around: write 10, read 10, write 12, read 12
    for (int i = 0; i < 10; i++) step(0, 1, DW'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 1, DW'(8'h30 + i), 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk("wrap_data", 32'(dout), 32'(8'h30 + i));
    end
    chk("wrap_count0", 32'(count), 32'd0);

    // Simultaneous wr & rd at count=5 for 20 cycles
    for (int i = 0; i < 5; i++) step(0, 1, DW'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, DW'($urandom_range(0, 255)), 1, 0);
    chk("steady_count5", 32'(count), 32'd5);

    // Full with wr & rd: read accepted, write rejected
    for (int i = 0; i < 11; i++) step(0, 1, DW'($urandom_range(0, 255)), 0, 0);
    step(0, 1, 8'hEE, 1, 0);
    chk("full_wr_rd_count", 32'(count), 32'd15);
    chk("full_wr_rd_ovf", 32'(overflow), 32'd1);

    // Reset mid-burst at count=9 with wr & rd high
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);
    chk("pre_rst_count9", 32'(count), 32'd9);
    step(1, 1, 8'h99, 1, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    step(0, 1, 8'h55, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("post_rst_data", 32'(dout), 32'h55);

    // Randomized phase, biased through empty/full boundaries
    for (int i = 0; i < 800; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 0) ? 70 : 30;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < wp),
           DW'($urandom),
           ($urandom_range(0, 99) < (100 - wp)),
           ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
